axi_err_slv: RTL and testbench
==============================

AXI_ERR_SLV -- requirements
Module: axi_err_slv

Interface
REQ-001 SHALL have parameter Resp, default axi_pkg::RESP_DECERR, response code driven on every B and R beat.
REQ-002 SHALL have parameter RespData, default 64'hCA11AB1EBADCAB1E, constant driven on every R data field.
REQ-003 SHALL have parameter MaxTrans, default 4, range 1..16, depth of the outstanding-AW FIFO.
REQ-004 SHALL have port clk_i input 1, the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_ni input 1, asynchronous active-low reset.
REQ-006 SHALL have aw_valid_i input 1, aw_ready_o output 1, aw_i input axi_pkg::aw_chan_t, the AW channel.
REQ-007 SHALL have w_valid_i input 1, w_ready_o output 1, w_i input axi_pkg::w_chan_t, the W channel.
REQ-008 SHALL have b_valid_o output 1, b_ready_i input 1, b_o output axi_pkg::b_chan_t, the B channel.
REQ-009 SHALL have ar_valid_i input 1, ar_ready_o output 1, ar_i input axi_pkg::ar_chan_t, the AR channel.
REQ-010 SHALL have r_valid_o output 1, r_ready_i input 1, r_o output axi_pkg::r_chan_t, the R channel.

Function
REQ-011 SHALL complete every handshake only in a cycle where valid and ready are both high; once b_valid_o or r_valid_o rises, it and its payload SHALL hold until the matching ready.
REQ-012 SHALL assert aw_ready_o iff the AW FIFO is not full; an accepted AW pushes aw_i.id.
REQ-013 SHALL assert w_ready_o iff the FIFO is non-empty and b_valid_o is low; W data and strb are discarded.
REQ-014 SHALL, on a W handshake with w_i.last=1, pop the FIFO and drive b_valid_o=1, b_o.id=popped id, b_o.resp=Resp in the next cycle.
REQ-015 SHALL clear b_valid_o on the cycle after b_valid_o and b_ready_i are both high.
REQ-016 SHALL, when the FIFO is full, accept a simultaneous AW push only if a pop occurs in the same cycle; when it is empty, a pushed AW SHALL NOT enable w_ready_o until the next cycle.
REQ-017 SHALL implement a read FSM with states R_IDLE and R_SEND; ar_ready_o=1 only in R_IDLE.
REQ-018 SHALL, on an AR handshake, capture id and len into an 8-bit beat counter and enter R_SEND next cycle (first r_valid_o one cycle after the AR handshake).
REQ-019 SHALL, in R_SEND, drive r_valid_o=1, r_o.id=captured id, r_o.data=RespData, r_o.resp=Resp, r_o.last=(counter==0).
REQ-020 SHALL decrement the counter on each R handshake and return to R_IDLE after the last-beat handshake; len=255 yields exactly 256 beats.
REQ-021 SHALL keep the write and read paths independent; a stalled B SHALL NOT block R, and vice versa.

Reset
REQ-022 SHALL, while rst_ni=0, empty the FIFO, enter R_IDLE, clear the counter, and drive b_valid_o=0, r_valid_o=0, aw_ready_o=0, w_ready_o=0, ar_ready_o=0.
REQ-023 SHALL drop in-flight bursts on reset mid-operation, with no B or R emitted for them afterwards; aw_ready_o and ar_ready_o SHALL rise the first cycle after reset deassertion.

Configuration
REQ-024 SHALL, with AXI_ERR_SLV_ATOP_EN defined, register each accepted AW with aw_i.atop[5]=1 in a one-entry ATOP register holding id and len, and emit an R burst of len+1 error beats with that id in addition to its B.
REQ-025 SHALL, with AXI_ERR_SLV_ATOP_EN defined, deassert aw_ready_o while the ATOP register is full and aw_i.atop[5]=1, and in R_IDLE serve the pending ATOP register ahead of AR (ar_ready_o=0 while pending).
REQ-026 SHALL, without AXI_ERR_SLV_ATOP_EN, ignore atop and produce only a B response for every AW.

Structure
REQ-027 SHALL take the channel structs, resp_t, len_t and RESP_* constants from axi_pkg; the read FSM state enum SHALL be local to the module.
REQ-028 SHALL instantiate one sub-module, axi_err_slv_fifo, a MaxTrans-deep id FIFO with full/empty flags and same-cycle push/pop.

Verification
REQ-029 SHALL verify: AW id=3 len=0, then one W last=1 -> one B with id=3, resp=2'b11, one cycle after the W.
REQ-030 SHALL verify: AR id=5 len=3, r_ready_i=1 -> four R beats with data=CA11AB1EBADCAB1E, last only on beat 4, then ar_ready_o=1.
REQ-031 SHALL verify: 5 AWs with no W and MaxTrans=4 -> aw_ready_o=0 after the 4th; one W last=1 -> aw_ready_o=1 again, B ids returned in order.
REQ-032 SHALL verify: b_ready_i held 0 for 10 cycles -> b_valid_o and b_o stable, w_ready_o=0, and the R path still completes an AR len=1.
REQ-033 SHALL verify: rst_ni pulsed low mid-burst during AR len=7 after beat 2 -> r_valid_o=0 immediately, and no further beats after release.
REQ-034 SHALL verify, with ATOP_EN: AW atop=6'b100000 id=9 len=1 plus W last -> one B id=9 and two R beats id=9, last on the second.

Source files
------------

// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - AXI channel types, widths and response codes
//
// Purpose: shared AXI4 channel structs, resp_t/len_t types and RESP_*
// constants for the error slave.
// Ports: none (package).

package axi_pkg;

  localparam int unsigned IdWidth   = 4;
  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 64;
  localparam int unsigned StrbWidth = DataWidth / 8;

  typedef logic [1:0]           resp_t;
  typedef logic [7:0]           len_t;
  typedef logic [IdWidth-1:0]   id_t;
  typedef logic [AddrWidth-1:0] addr_t;
  typedef logic [DataWidth-1:0] data_t;
  typedef logic [StrbWidth-1:0] strb_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  typedef struct packed {
    id_t        id;
    addr_t      addr;
    len_t       len;
    logic [2:0] size;
    logic [1:0] burst;
    logic [5:0] atop;
  } aw_chan_t;

  typedef struct packed {
    data_t data;
    strb_t strb;
    logic  last;
  } w_chan_t;

  typedef struct packed {
    id_t   id;
    resp_t resp;
  } b_chan_t;

  typedef struct packed {
    id_t        id;
    addr_t      addr;
    len_t       len;
    logic [2:0] size;
    logic [1:0] burst;
  } ar_chan_t;

  typedef struct packed {
    id_t   id;
    data_t data;
    resp_t resp;
    logic  last;
  } r_chan_t;

endpackage

// File: rtl/axi_err_slv_fifo.sv
// rtl/axi_err_slv_fifo.sv - outstanding write-id FIFO with same-cycle push/pop
//
// Purpose: Depth-entry FIFO holding ids of accepted AW beats awaiting their
// last W beat.
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   push_i, data_i    write an entry (caller guarantees not full unless pop_i)
//   pop_i, data_o     remove head entry; data_o shows head (valid if !empty_o)
//   full_o, empty_o   occupancy flags

module axi_err_slv_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastIdx = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_q, rd_q;
  logic [CntW-1:0]  cnt_q;

  assign full_o  = (cnt_q == FullCnt);
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rd_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= (wr_q == LastIdx) ? '0 : wr_q + 1'b1;
      if (pop_i)  rd_q <= (rd_q == LastIdx) ? '0 : rd_q + 1'b1;
      if (push_i && !pop_i)      cnt_q <= cnt_q + 1'b1;
      else if (pop_i && !push_i) cnt_q <= cnt_q - 1'b1;
    end
  end

  // Storage needs no reset: entries are only read once counted in cnt_q.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/axi_err_slv.sv
// rtl/axi_err_slv.sv - AXI slave answering every transaction with an error
//
// Purpose: accepts all AXI writes/reads and responds with Resp on B and R;
// R data is the constant RespData. Optional macro AXI_ERR_SLV_ATOP_EN adds
// an R burst for atomic AWs (aw_i.atop[5]=1).
// Ports:
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   aw_valid_i/aw_ready_o/aw_i         AW channel
//   w_valid_i/w_ready_o/w_i            W channel (data/strb discarded)
//   b_valid_o/b_ready_i/b_o            B channel
//   ar_valid_i/ar_ready_o/ar_i         AR channel
//   r_valid_o/r_ready_i/r_o            R channel

module axi_err_slv
  import axi_pkg::*;
#(
  parameter resp_t       Resp     = axi_pkg::RESP_DECERR,
  parameter logic [63:0] RespData = 64'hCA11AB1EBADCAB1E,
  parameter int unsigned MaxTrans = 4
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     aw_valid_i,
  output logic     aw_ready_o,
  input  aw_chan_t aw_i,
  input  logic     w_valid_i,
  output logic     w_ready_o,
  input  w_chan_t  w_i,
  output logic     b_valid_o,
  input  logic     b_ready_i,
  output b_chan_t  b_o,
  input  logic     ar_valid_i,
  output logic     ar_ready_o,
  input  ar_chan_t ar_i,
  output logic     r_valid_o,
  input  logic     r_ready_i,
  output r_chan_t  r_o
);

  typedef enum logic {R_IDLE, R_SEND} r_state_e;

  r_state_e state_q, state_d;
  id_t      r_id_q, r_id_d;
  len_t     cnt_q, cnt_d;

  logic fifo_full, fifo_empty, push, pop;
  id_t  fifo_id;
  logic b_valid_q;
  id_t  b_id_q;

  logic atop_block, atop_take, atop_valid_q;
  id_t  atop_id_q;
  len_t atop_len_q;

  // ---------------- write path ----------------
  assign w_ready_o = ~fifo_empty & ~b_valid_q;
  assign pop       = w_valid_i & w_ready_o & w_i.last;
  // A full FIFO still takes an AW when the head is leaving this cycle.
  assign aw_ready_o = rst_ni & (~fifo_full | pop) & ~atop_block;
  assign push       = aw_valid_i & aw_ready_o;

  axi_err_slv_fifo #(
    .Depth (MaxTrans),
    .Width (IdWidth)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (aw_i.id),
    .pop_i   (pop),
    .data_o  (fifo_id),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // pop cannot coincide with b_valid_q because w_ready_o is low then.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      b_valid_q <= 1'b0;
      b_id_q    <= '0;
    end else if (pop) begin
      b_valid_q <= 1'b1;
      b_id_q    <= fifo_id;
    end else if (b_valid_q && b_ready_i) begin
      b_valid_q <= 1'b0;
    end
  end

  assign b_valid_o = b_valid_q;
  assign b_o       = '{id: b_id_q, resp: Resp};

  // ---------------- atomic register ----------------
`ifdef AXI_ERR_SLV_ATOP_EN
  assign atop_block = atop_valid_q & aw_i.atop[5];

  // Take and fill never collide: a fill needs atop_block low, i.e. empty.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      atop_valid_q <= 1'b0;
      atop_id_q    <= '0;
      atop_len_q   <= '0;
    end else if (push && aw_i.atop[5]) begin
      atop_valid_q <= 1'b1;
      atop_id_q    <= aw_i.id;
      atop_len_q   <= aw_i.len;
    end else if (atop_take) begin
      atop_valid_q <= 1'b0;
    end
  end
`else
  assign atop_block   = 1'b0;
  assign atop_valid_q = 1'b0;
  assign atop_id_q    = '0;
  assign atop_len_q   = '0;
`endif

  // ---------------- read path ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= R_IDLE;
      r_id_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      r_id_q  <= r_id_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    r_id_d     = r_id_q;
    cnt_d      = cnt_q;
    atop_take  = 1'b0;
    ar_ready_o = 1'b0;
    r_valid_o  = 1'b0;
    r_o        = '0;
    case (state_q)
      R_IDLE: begin
        // A pending atomic burst wins over a new AR.
        if (atop_valid_q) begin
          atop_take = 1'b1;
          r_id_d    = atop_id_q;
          cnt_d     = atop_len_q;
          state_d   = R_SEND;
        end else begin
          ar_ready_o = rst_ni;
          if (ar_valid_i && rst_ni) begin
            r_id_d  = ar_i.id;
            cnt_d   = ar_i.len;
            state_d = R_SEND;
          end
        end
      end
      R_SEND: begin
        r_valid_o = 1'b1;
        r_o       = '{id: r_id_q, data: RespData, resp: Resp, last: (cnt_q == '0)};
        if (r_ready_i) begin
          if (cnt_q == '0) state_d = R_IDLE;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  // Address, size, burst, W data/strb carry no meaning for an error slave.
  logic unused_bits;
  assign unused_bits = ^{aw_i, w_i, ar_i, atop_take};

endmodule

// File: tb/tb_axi_err_slv.sv
// tb/tb_axi_err_slv.sv - self-checking bench for axi_err_slv
//
// Purpose: drives directed AXI traffic, compares every cycle against a
// queue-based transaction model, and pins key cases with literal values.
// Define AXI_ERR_SLV_ATOP_EN to also exercise the atomic R burst.

module tb_axi_err_slv;
  import axi_pkg::*;

  localparam int MAXT = 4;
  localparam logic [63:0] DATA_K = 64'hCA11AB1EBADCAB1E;

  logic     clk = 1'b0;
  logic     rst_ni;
  logic     aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
  logic     ar_valid, ar_ready, r_valid, r_ready;
  aw_chan_t aw_s;
  w_chan_t  w_s;
  b_chan_t  b_s;
  ar_chan_t ar_s;
  r_chan_t  r_s;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  axi_err_slv dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .aw_valid_i(aw_valid), .aw_ready_o(aw_ready), .aw_i(aw_s),
    .w_valid_i(w_valid), .w_ready_o(w_ready), .w_i(w_s),
    .b_valid_o(b_valid), .b_ready_i(b_ready), .b_o(b_s),
    .ar_valid_i(ar_valid), .ar_ready_o(ar_ready), .ar_i(ar_s),
    .r_valid_o(r_valid), .r_ready_i(r_ready), .r_o(r_s)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- transaction model ----------------
  id_t wq[$];            // writes waiting for their last W
  bit  m_bv;  id_t m_bid;
  bit  m_rbusy; id_t m_rid; int m_rrem;  // beats still to send
  bit  m_apend; id_t m_aid; int m_alen;

  function automatic bit m_w_ready();
    return (wq.size() > 0) && !m_bv;
  endfunction

  function automatic bit m_pop();
    return w_valid && m_w_ready() && w_s.last;
  endfunction

  function automatic bit m_aw_ready();
    bit ok;
    ok = (wq.size() < MAXT) || m_pop();
`ifdef AXI_ERR_SLV_ATOP_EN
    if (m_apend && aw_s.atop[5]) ok = 1'b0;
`endif
    return ok;
  endfunction

  function automatic bit m_ar_ready();
    return !m_rbusy && !m_apend;
  endfunction

  bit h_pop, h_aw, h_b, h_r, h_ar, h_serve;

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      wq.delete();
      m_bv = 0; m_rbusy = 0; m_rrem = 0; m_apend = 0;
    end else begin
      h_pop   = m_pop();
      h_aw    = aw_valid && m_aw_ready();
      h_b     = m_bv && b_ready;
      h_r     = m_rbusy && r_ready;
      h_ar    = ar_valid && m_ar_ready();
      h_serve = !m_rbusy && m_apend;
      if (h_b) m_bv = 0;
      if (h_pop) begin
        m_bid = wq.pop_front();
        m_bv  = 1;
      end
      if (h_aw) wq.push_back(aw_s.id);
      if (h_r) begin
        m_rrem--;
        if (m_rrem == 0) m_rbusy = 0;
      end else if (h_serve) begin
        m_rbusy = 1; m_rid = m_aid; m_rrem = m_alen + 1; m_apend = 0;
      end else if (h_ar) begin
        m_rbusy = 1; m_rid = ar_s.id; m_rrem = int'(ar_s.len) + 1;
      end
`ifdef AXI_ERR_SLV_ATOP_EN
      if (h_aw && aw_s.atop[5]) begin
        m_apend = 1; m_aid = aw_s.id; m_alen = int'(aw_s.len);
      end
`endif
    end
  end

  always @(negedge clk) begin
    if (!rst_ni) begin
      chk("rst_aw_ready", aw_ready, 0);
      chk("rst_w_ready", w_ready, 0);
      chk("rst_ar_ready", ar_ready, 0);
      chk("rst_b_valid", b_valid, 0);
      chk("rst_r_valid", r_valid, 0);
    end else begin
      chk("m_aw_ready", aw_ready, m_aw_ready());
      chk("m_w_ready", w_ready, m_w_ready());
      chk("m_ar_ready", ar_ready, m_ar_ready());
      chk("m_b_valid", b_valid, m_bv);
      if (m_bv) begin
        chk("m_b_id", b_s.id, m_bid);
        chk("m_b_resp", b_s.resp, 2'b11);
      end
      chk("m_r_valid", r_valid, m_rbusy);
      if (m_rbusy) begin
        chk("m_r_id", r_s.id, m_rid);
        chk("m_r_data", r_s.data, DATA_K);
        chk("m_r_resp", r_s.resp, 2'b11);
        chk("m_r_last", r_s.last, m_rrem == 1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  int n, rb, last_at, extra, nb, nr;

  initial begin
    rst_ni = 0; aw_valid = 0; aw_s = '0; w_valid = 0; w_s = '0; b_ready = 0;
    ar_valid = 0; ar_s = '0; r_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("t0_aw_ready", aw_ready, 0);
    chk("t0_ar_ready", ar_ready, 0);
    chk("t0_b_valid", b_valid, 0);
    chk("t0_r_valid", r_valid, 0);
    rst_ni = 1;
    tick();
    chk("t0_aw_ready_up", aw_ready, 1);
    chk("t0_ar_ready_up", ar_ready, 1);

    // single write: id=3 len=0
    aw_valid = 1; aw_s.id = 4'd3; aw_s.len = 8'd0;
    tick();
    aw_valid = 0;
    w_valid = 1; w_s.last = 1; w_s.data = 64'h1234; w_s.strb = 8'hFF;
    #1;
    chk("t1_w_ready", w_ready, 1);
    tick();
    w_valid = 0;
    chk("t1_b_valid", b_valid, 1);
    chk("t1_b_id", b_s.id, 3);
    chk("t1_b_resp", b_s.resp, 2'b11);
    b_ready = 1;
    tick();
    chk("t1_b_clear", b_valid, 0);

    // read burst: id=5 len=3
    r_ready = 1; ar_valid = 1; ar_s.id = 4'd5; ar_s.len = 8'd3;
    #1;
    chk("t2_ar_ready", ar_ready, 1);
    tick();
    ar_valid = 0;
    rb = 0; last_at = 0;
    for (int c = 0; c < 20 && last_at == 0; c++) begin
      if (r_valid) begin
        rb++;
        chk("t2_data", r_s.data, 64'hCA11AB1EBADCAB1E);
        chk("t2_id", r_s.id, 5);
        if (r_s.last) last_at = rb;
      end
      tick();
    end
    chk("t2_beats", rb, 4);
    chk("t2_last_beat", last_at, 4);
    chk("t2_ar_ready_after", ar_ready, 1);

    // fill the id FIFO, then free a slot with one W
    for (int i = 0; i < 4; i++) begin
      aw_valid = 1; aw_s.id = id_t'(i); aw_s.atop = '0;
      #1;
      chk("t3_aw_ready", aw_ready, 1);
      tick();
    end
    aw_s.id = 4'd4;
    #1;
    chk("t3_full_aw_ready", aw_ready, 0);
    tick(); tick();
    chk("t3_still_full", aw_ready, 0);
    w_valid = 1; w_s.last = 1;
    #1;
    chk("t3_pop_aw_ready", aw_ready, 1);
    tick();
    aw_valid = 0;
    n = 0;
    for (int c = 0; c < 60 && n < 5; c++) begin
      if (b_valid && b_ready) begin
        chk("t3_b_order", b_s.id, n);
        n++;
      end
      if (n >= 5) w_valid = 0;
      tick();
    end
    w_valid = 0;
    chk("t3_b_count", n, 5);

    // stalled B while a read completes
    b_ready = 0;
    aw_valid = 1; aw_s.id = 4'd6;
    tick();
    aw_s.id = 4'd7; w_valid = 1; w_s.last = 1;
    tick();
    aw_valid = 0;
    ar_valid = 1; ar_s.id = 4'd2; ar_s.len = 8'd1; r_ready = 1;
    tick();
    ar_valid = 0;
    rb = 0;
    for (int c = 0; c < 10; c++) begin
      chk("t4_b_valid", b_valid, 1);
      chk("t4_b_id", b_s.id, 6);
      chk("t4_w_ready", w_ready, 0);
      if (r_valid && r_ready) rb++;
      tick();
    end
    chk("t4_r_beats", rb, 2);
    chk("t4_ar_ready", ar_ready, 1);
    b_ready = 1;
    n = 0;
    for (int c = 0; c < 20 && n < 2; c++) begin
      if (b_valid && b_ready) begin
        chk("t4_drain_id", b_s.id, 6 + n);
        n++;
      end
      if (n >= 2) w_valid = 0;
      tick();
    end
    w_valid = 0;
    chk("t4_drain_count", n, 2);

    // reset in the middle of a len=7 read
    ar_valid = 1; ar_s.id = 4'd1; ar_s.len = 8'd7;
    tick();
    ar_valid = 0;
    rb = 0;
    for (int c = 0; c < 10 && rb < 2; c++) begin
      if (r_valid) rb++;
      tick();
    end
    chk("t5_beats_before", rb, 2);
    rst_ni = 0;
    #1;
    chk("t5_r_valid_rst", r_valid, 0);
    chk("t5_ar_ready_rst", ar_ready, 0);
    chk("t5_aw_ready_rst", aw_ready, 0);
    tick();
    rst_ni = 1;
    #1;
    chk("t5_ar_ready_up", ar_ready, 1);
    chk("t5_aw_ready_up", aw_ready, 1);
    extra = 0;
    for (int c = 0; c < 15; c++) begin
      if (r_valid || b_valid) extra++;
      tick();
    end
    chk("t5_no_beats", extra, 0);

`ifdef AXI_ERR_SLV_ATOP_EN
    // atomic write: B plus a two-beat R burst
    b_ready = 1; r_ready = 1;
    aw_valid = 1; aw_s = '0; aw_s.id = 4'd9; aw_s.len = 8'd1; aw_s.atop = 6'b100000;
    tick();
    aw_valid = 0; aw_s.atop = '0;
    w_valid = 1; w_s.last = 1;
    tick();
    w_valid = 0;
    nb = 0; nr = 0;
    for (int c = 0; c < 20; c++) begin
      if (b_valid && b_ready) begin
        chk("t6_b_id", b_s.id, 9);
        nb++;
      end
      if (r_valid && r_ready) begin
        nr++;
        chk("t6_r_id", r_s.id, 9);
        chk("t6_r_last", r_s.last, nr == 2);
      end
      tick();
    end
    chk("t6_b_count", nb, 1);
    chk("t6_r_count", nr, 2);
`endif

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
